fifo_line_reader: RTL and testbench
===================================

FIFO_LINE_READER -- requirements
Module: fifo_line_reader

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 24: pixel width (RGB888).
- LEVEL_WIDTH, default 12: width of the FIFO read water level.
- H_ACTIVE, default 1920: pixels per line, range 2..2047.
- V_ACTIVE, default 1080: lines per frame, range 1..4095.
- RD_LATENCY, default 1: FIFO rd_en-to-data latency in cycles. Legal values are 1 and 2.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock for all logic.
- rst, in, 1: synchronous, active-high reset.
- fifo_rd_data, in, DATA_WIDTH: FIFO read data.
- fifo_rd_empty, in, 1: FIFO empty flag.
- fifo_rd_water_level, in, LEVEL_WIDTH: FIFO occupancy.
- fifo_rd_en, out, 1: FIFO read enable.
- m_data, out, DATA_WIDTH: output pixel.
- m_valid, out, 1: output valid.
- m_ready, in, 1: downstream ready.
- m_sol, out, 1: first pixel of a line.
- m_eol, out, 1: last pixel of a line.
- m_sof, out, 1: first pixel of a frame.
- m_eof, out, 1: last pixel of a frame.
- line_done, out, 1: one-cycle pulse after a line completes.
REQ-003 The clock SHALL be clk and the reset SHALL be rst. rst is synchronous and active-high, sampled only on the rising edge of clk.

Function
REQ-004 The state machine SHALL have the states IDLE, STREAM and DRAIN.
REQ-005 IDLE -> STREAM SHALL occur when fifo_rd_water_level >= H_ACTIVE, so that a whole line is buffered before it is read. Otherwise the block SHALL remain in IDLE.
REQ-006 In STREAM, the issue counter rd_cnt SHALL count fifo_rd_en pulses from 0. The block SHALL go STREAM -> DRAIN in the cycle that rd_cnt reaches H_ACTIVE.
REQ-007 DRAIN -> IDLE SHALL occur on the handshake (m_valid && m_ready) of the pixel with out_cnt == H_ACTIVE-1. line_done SHALL pulse for exactly one cycle in the following cycle.
REQ-008 The output buffer SHALL be a skid FIFO of SKID_DEPTH = RD_LATENCY+1 entries. inflight SHALL count reads issued but not yet returned, range 0..RD_LATENCY.
REQ-009 fifo_rd_en SHALL be high when all of the following hold:
- state == STREAM;
- !fifo_rd_empty;
- rd_cnt < H_ACTIVE;
- occupancy + inflight - (m_valid && m_ready) < SKID_DEPTH.
REQ-010 fifo_rd_en SHALL never be asserted while fifo_rd_empty = 1 (no underflow), and the skid buffer SHALL never overflow.
REQ-011 Data returned RD_LATENCY cycles after fifo_rd_en SHALL be written into the skid buffer. Buffer push and pop in the same cycle SHALL both take effect.
REQ-012 m_valid SHALL equal (occupancy != 0), and m_data SHALL be the head entry.
REQ-013 m_data, m_valid, m_sol, m_eol, m_sof and m_eof SHALL hold stable while m_valid && !m_ready.
REQ-014 With m_ready held at 1 and the FIFO non-empty, throughput SHALL be one pixel per cycle. The first m_valid SHALL appear RD_LATENCY+1 cycles after the IDLE -> STREAM transition.
REQ-015 out_cnt SHALL increment on each handshake and wrap to 0 after H_ACTIVE-1. line_cnt SHALL increment on each m_eol handshake and wrap to 0 after V_ACTIVE-1.
REQ-016 Output flags SHALL be decoded as:
- m_sol = (out_cnt == 0) && m_valid;
- m_eol = (out_cnt == H_ACTIVE-1) && m_valid;
- m_sof = m_sol && (line_cnt == 0);
- m_eof = m_eol && (line_cnt == V_ACTIVE-1).
REQ-017 If V_ACTIVE == 1, every line SHALL assert both m_sof and m_eof.
REQ-018 If fifo_rd_empty rises mid-line, issue SHALL pause with counters held. Issue SHALL resume when empty clears, with no pixel lost or duplicated.
REQ-019 When a line finishes (DRAIN -> IDLE) and the water level condition already holds, the block SHALL re-enter STREAM in the next cycle.

Reset
REQ-020 While rst = 1 the block SHALL force the following:
- state = IDLE;
- rd_cnt, out_cnt, line_cnt, inflight and skid occupancy = 0;
- fifo_rd_en, m_valid, m_sol, m_eol, m_sof, m_eof and line_done = 0;
- m_data = 0.
REQ-021 Reset asserted mid-line SHALL discard all buffered and in-flight data. FIFO data returning during or within RD_LATENCY cycles after reset SHALL NOT be written to the skid buffer.
REQ-022 After rst deasserts, the first output pixel SHALL carry m_sof = 1 and m_sol = 1.

Verification
Settings for all scenarios: H_ACTIVE=4, V_ACTIVE=2, RD_LATENCY=1.
REQ-023 Reset, then hold water_level=3 with FIFO non-empty -> fifo_rd_en stays 0 and m_valid stays 0. Raise water_level to 4 -> four reads are issued; pixels P0..P3 are output on consecutive cycles with m_ready=1; P0 has m_sof and m_sol, P3 has m_eol; line_done pulses once.
REQ-024 Stream 2 full lines with m_ready=1 -> 8 handshakes; m_sof only on pixel 0; m_eof only on pixel 7; line_cnt returns to 0.
REQ-025 m_ready=0 for 5 cycles mid-line -> fifo_rd_en stops after at most 2 outstanding entries; m_data and flags stay stable; no pixel is lost or duplicated when m_ready returns to 1.
REQ-026 fifo_rd_empty pulsed high for 3 cycles after pixel 1 is issued -> no fifo_rd_en while empty; output order is P0,P1,P2,P3.
REQ-027 rst asserted one cycle after a read is issued mid-line -> all outputs are 0 on the next cycle; the returned data is dropped; the next line starts with m_sof=1.
REQ-028 Random m_ready (50%) and random empty toggling over 100 lines -> a scoreboard sees data in order, the flag positions are correct, and assertions for REQ-010 never fire.

Source files
------------

// File: rtl/fifo_line_reader.sv
// ----------------------------------------------------------------------------
// fifo_line_reader
//
// Pulls one video line at a time out of an upstream FIFO and presents it as a
// valid/ready pixel stream with line and frame markers. A line is only started
// once the FIFO holds a whole line. Reads are issued into a small skid buffer
// sized so that every read in flight always has a slot, which lets the
// downstream stall at any time without losing data.
//
// Ports
//   clk                 : single clock for all logic
//   rst                 : synchronous, active-high reset
//   fifo_rd_data        : FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_rd_empty       : FIFO empty flag
//   fifo_rd_water_level : FIFO occupancy
//   fifo_rd_en          : FIFO read enable
//   m_data / m_valid    : output pixel and valid
//   m_ready             : downstream ready
//   m_sol / m_eol       : first / last pixel of a line
//   m_sof / m_eof       : first / last pixel of a frame
//   line_done           : one-cycle pulse after the last pixel of a line is taken
// ----------------------------------------------------------------------------
module fifo_line_reader #(
  parameter int DATA_WIDTH  = 24,
  parameter int LEVEL_WIDTH = 12,
  parameter int H_ACTIVE    = 1920,
  parameter int V_ACTIVE    = 1080,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   fifo_rd_en,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_sol,
  output logic                   m_eol,
  output logic                   m_sof,
  output logic                   m_eof,
  output logic                   line_done
);

  localparam int SKID_DEPTH = RD_LATENCY + 1;
  localparam int PTR_W      = $clog2(SKID_DEPTH);
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int INF_W      = $clog2(RD_LATENCY + 1);
  localparam int SUM_W      = OCC_W + 2;
  localparam int CNT_W      = $clog2(H_ACTIVE + 1);
  localparam int LN_W       = $clog2(V_ACTIVE + 1);

  localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [LN_W-1:0]  V_LAST = LN_W'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [LN_W-1:0]   line_cnt_q;
  logic              line_done_q;

  // Read-return tracking: one valid bit per pipeline stage of the FIFO.
  logic              ret_vld_q [RD_LATENCY];
  logic [INF_W-1:0]  inflight_q, inflight_d;

  // Skid buffer
  logic [DATA_WIDTH-1:0] skid_mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic hs;
  logic ret;
  logic room;
  logic level_ok;
  logic eol_pos;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign hs       = m_valid && m_ready;
  assign ret      = ret_vld_q[RD_LATENCY-1];
  assign level_ok = (32'(fifo_rd_water_level) >= 32'(H_ACTIVE));
  assign eol_pos  = (out_cnt_q == H_LAST);

  // A new read is only issued if the skid buffer can hold it together with
  // everything already in flight, crediting the pop taking place this cycle.
  assign room = (SUM_W'(occ_q) + SUM_W'(inflight_q) - SUM_W'(hs)) < SUM_W'(SKID_DEPTH);

  // Outputs are forced low combinationally during reset so that nothing
  // leaks out in the first reset cycle, before the registers have cleared.
  assign fifo_rd_en = !rst && (state_q == STREAM) && !fifo_rd_empty &&
                      (rd_cnt_q < H_MAX) && room;
  assign m_valid    = !rst && (occ_q != '0);
  assign m_data     = m_valid ? skid_mem_q[rd_ptr_q] : '0;
  assign m_sol      = m_valid && (out_cnt_q == '0);
  assign m_eol      = m_valid && eol_pos;
  assign m_sof      = m_sol && (line_cnt_q == '0);
  assign m_eof      = m_eol && (line_cnt_q == V_LAST);
  assign line_done  = !rst && line_done_q;

  assign inflight_d = inflight_q + INF_W'(fifo_rd_en) - INF_W'(ret);
  assign occ_d      = occ_q + OCC_W'(ret) - OCC_W'(hs);

  // --------------------------------------------------------------------------
  // Control FSM and position counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      line_cnt_q  <= '0;
      line_done_q <= 1'b0;
    end else begin
      line_done_q <= 1'b0;

      if (hs) begin
        out_cnt_q <= eol_pos ? '0 : out_cnt_q + CNT_W'(1);
        if (eol_pos) begin
          line_cnt_q <= (line_cnt_q == V_LAST) ? '0 : line_cnt_q + LN_W'(1);
        end
      end

      case (state_q)
        IDLE: begin
          rd_cnt_q <= '0;
          if (level_ok) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (fifo_rd_en) begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            // Last read of the line: remaining work is only emptying the skid.
            if (rd_cnt_q == H_LAST) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (hs && eol_pos) begin
            state_q     <= IDLE;
            line_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read-return pipeline. Cleared on reset so data for reads issued before
  // reset is never captured.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_ret
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) ret_vld_q[gi] <= 1'b0;
        else     ret_vld_q[gi] <= fifo_rd_en;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (rst) ret_vld_q[gi] <= 1'b0;
        else     ret_vld_q[gi] <= ret_vld_q[gi-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Skid buffer bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      if (ret) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (hs)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ret) begin
      skid_mem_q[wr_ptr_q] <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_line_reader.sv
// ----------------------------------------------------------------------------
// Testbench for fifo_line_reader (H_ACTIVE=4, V_ACTIVE=2, RD_LATENCY=1).
// An upstream FIFO model feeds random pixels; every pushed pixel also goes
// into an expected queue together with the markers it must carry, computed
// from its position in the line and frame. A negedge monitor checks each
// handshake against that queue plus the protocol rules.
// ----------------------------------------------------------------------------
module tb_fifo_line_reader;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int L  = 1;
  localparam int DW = 24;
  localparam int LW = 12;
  localparam int SKID = L + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty;
  logic [LW-1:0] fifo_rd_water_level;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_sol, m_eol, m_sof, m_eof, line_done;

  fifo_line_reader #(
    .DATA_WIDTH (DW),
    .LEVEL_WIDTH(LW),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .RD_LATENCY (L)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_empty      (fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .fifo_rd_en         (fifo_rd_en),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_sol              (m_sol),
    .m_eol              (m_eol),
    .m_sof              (m_sof),
    .m_eof              (m_eof),
    .line_done          (line_done)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model
  logic [DW-1:0] pix_mem [0:8191];
  int   wr_idx = 0;
  int   rd_idx = 0;
  int   lvl_cap = 4095;
  logic force_empty = 1'b0;
  logic flush_req = 1'b0;

  assign fifo_rd_empty       = force_empty || (wr_idx == rd_idx);
  assign fifo_rd_water_level = ((wr_idx - rd_idx) < lvl_cap) ? LW'(wr_idx - rd_idx) : LW'(lvl_cap);

  always @(posedge clk) begin
    if (flush_req) begin
      rd_idx <= wr_idx;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= pix_mem[rd_idx];
      rd_idx       <= rd_idx + 1;
    end
  end

  // Scoreboard state
  logic [27:0] exp_q [$];
  int n_cmp = 0;
  int n_fail = 0;
  int line_no = 0;
  int hs_cnt = 0, rd_issued = 0, ld_cnt = 0, sof_cnt = 0, eof_cnt = 0;
  int sof_pos = -1, eof_pos = -1;
  int pending = 0;
  bit prev_stall = 1'b0, prev_eol_hs = 1'b0;
  logic [27:0] prev_obs = '0;
  logic [27:0] obs;

  assign obs = {m_sof, m_eof, m_sol, m_eol, m_data};

  // Expected markers derived from the pixel's position in line and frame.
  function automatic logic [27:0] ref_pix(input logic [DW-1:0] d, input int k, input int ln);
    logic sol, eol, sof, eof;
    sol = (k == 0);
    eol = (k == H - 1);
    sof = sol && ((ln % V) == 0);
    eof = eol && ((ln % V) == V - 1);
    return {sof, eof, sol, eol, d};
  endfunction

  task automatic push_line();
    logic [DW-1:0] d;
    for (int k = 0; k < H; k++) begin
      d = DW'($urandom);
      pix_mem[wr_idx] = d;
      exp_q.push_back(ref_pix(d, k, line_no));
      wr_idx = wr_idx + 1;
    end
    line_no = line_no + 1;
  endtask

  task automatic clear_counters();
    exp_q.delete();
    line_no = 0; hs_cnt = 0; rd_issued = 0; ld_cnt = 0;
    sof_cnt = 0; eof_cnt = 0; sof_pos = -1; eof_pos = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; flush_req = 1'b1; m_ready = 1'b0; force_empty = 1'b0; lvl_cap = 4095;
    clear_counters();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; flush_req = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      @(negedge clk); #1;
      c++;
    end
    ok = (exp_q.size() == 0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Protocol and data monitor
  always @(negedge clk) begin
    if (rst) begin
      pending = 0; prev_stall = 1'b0; prev_eol_hs = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        n_cmp++;
        if (fifo_rd_empty) begin
          n_fail++;
          $display("FAIL rd_while_empty: fifo_rd_en=1 with fifo_rd_empty=%0b, required no read", fifo_rd_empty);
        end
        n_cmp++;
        if (pending + 1 - int'(m_valid && m_ready) > SKID) begin
          n_fail++;
          $display("FAIL skid_overflow: outstanding %0d after read, limit %0d", pending + 1 - int'(m_valid && m_ready), SKID);
        end
        rd_issued++;
      end
      if (prev_stall) begin
        n_cmp++;
        if ({m_valid, obs} !== {1'b1, prev_obs}) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%0b %h, required valid=1 %h", m_valid, obs, prev_obs);
        end
      end
      if (line_done || prev_eol_hs) begin
        n_cmp++;
        if (line_done !== prev_eol_hs) begin
          n_fail++;
          $display("FAIL line_done_pulse: got %0b, required %0b", line_done, prev_eol_hs);
        end
      end
      if (line_done) ld_cnt++;
      if (m_valid && m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pixel_extra: got %h, required no pixel", obs);
        end else begin
          logic [27:0] e;
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL pixel_%0d: got %h, required %h", hs_cnt, obs, e);
          end
        end
        $display("hs %0d data=%06h sof=%0b eof=%0b sol=%0b eol=%0b", hs_cnt, m_data, m_sof, m_eof, m_sol, m_eol);
        if (m_sof) begin
          sof_cnt++;
          if (sof_pos < 0) sof_pos = hs_cnt;
        end
        if (m_eof) begin
          eof_cnt++;
          eof_pos = hs_cnt;
        end
        hs_cnt++;
      end
      pending = pending + int'(fifo_rd_en) - int'(m_valid && m_ready);
      prev_stall  = m_valid && !m_ready;
      prev_obs    = obs;
      prev_eol_hs = m_valid && m_ready && m_eol;
    end
  end

  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({fifo_rd_en, m_valid, m_sol, m_eol, m_sof, m_eof, line_done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {fifo_rd_en, m_valid, m_sol, m_eol, m_sof, m_eof, line_done});
    end
    n_cmp++;
    if (m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 000000", m_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({fifo_rd_en, m_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL post_reset_idle: got rd_en,valid=%b, required 00", {fifo_rd_en, m_valid});
      end
    end
  endtask

  task automatic test_threshold();
    logic [15:0] rd_vec, v_vec, ld_vec;
    @(posedge clk); #1;
    m_ready = 1'b1;
    lvl_cap = 3;
    push_line();
    repeat (6) begin
      @(negedge clk);
      n_cmp++;
      if ({fifo_rd_en, m_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL below_level: got rd_en,valid=%b, required 00", {fifo_rd_en, m_valid});
      end
    end
    @(posedge clk); #1;
    lvl_cap = 4095;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      rd_vec[c] = fifo_rd_en;
      v_vec[c]  = m_valid;
      ld_vec[c] = line_done;
    end
    // Level seen at the next edge, reads in the following 4 cycles, first
    // pixel RD_LATENCY+1 cycles after entering STREAM, done pulse after P3.
    n_cmp++;
    if (rd_vec !== 16'b0000_0000_0001_1110) begin
      n_fail++;
      $display("FAIL thr_reads: got %b, required %b", rd_vec, 16'b0000_0000_0001_1110);
    end
    n_cmp++;
    if (v_vec !== 16'b0000_0000_0111_1000) begin
      n_fail++;
      $display("FAIL thr_valid: got %b, required %b", v_vec, 16'b0000_0000_0111_1000);
    end
    n_cmp++;
    if (ld_vec !== 16'b0000_0000_1000_0000) begin
      n_fail++;
      $display("FAIL thr_line_done: got %b, required %b", ld_vec, 16'b0000_0000_1000_0000);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL thr_left: got %0d pixels pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_two_lines();
    bit ok;
    do_reset();
    m_ready = 1'b1;
    push_line();
    push_line();
    wait_drain(80, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL two_drain: got %0d pixels pending, required 0", exp_q.size());
    end
    n_cmp++;
    if (hs_cnt != 8) begin
      n_fail++;
      $display("FAIL two_hs: got %0d, required 8", hs_cnt);
    end
    n_cmp++;
    if ({sof_cnt, sof_pos, eof_cnt, eof_pos} != {32'd1, 32'd0, 32'd1, 32'd7}) begin
      n_fail++;
      $display("FAIL two_frame_flags: got sof %0d@%0d eof %0d@%0d, required sof 1@0 eof 1@7",
               sof_cnt, sof_pos, eof_cnt, eof_pos);
    end
    n_cmp++;
    if (ld_cnt != 2) begin
      n_fail++;
      $display("FAIL two_line_done: got %0d, required 2", ld_cnt);
    end
    // Third line opens a new frame again.
    @(posedge clk); #1;
    push_line();
    wait_drain(40, ok);
    n_cmp++;
    if (!ok || sof_cnt != 2) begin
      n_fail++;
      $display("FAIL frame_wrap: got sof count %0d pending %0d, required 2 and 0", sof_cnt, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int c;
    do_reset();
    m_ready = 1'b1;
    push_line();
    c = 0;
    while (hs_cnt < 1 && c < 40) begin
      @(negedge clk); #1;
      c++;
    end
    n_cmp++;
    if (hs_cnt < 1) begin
      n_fail++;
      $display("FAIL bp_start: got %0d handshakes, required 1", hs_cnt);
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_valid_%0d: got %0b, required 1", s, m_valid);
      end
      if (s >= 1) begin
        n_cmp++;
        if (fifo_rd_en !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_rd_stop_%0d: got %0b, required 0", s, fifo_rd_en);
        end
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain(40, ok);
    n_cmp++;
    if (!ok || hs_cnt != 4 || ld_cnt != 1) begin
      n_fail++;
      $display("FAIL bp_result: got hs %0d line_done %0d pending %0d, required 4 1 0", hs_cnt, ld_cnt, exp_q.size());
    end
  endtask

  task automatic test_empty_pause();
    bit ok;
    int c;
    do_reset();
    m_ready = 1'b1;
    push_line();
    c = 0;
    while (rd_issued < 2 && c < 40) begin
      @(negedge clk); #1;
      c++;
    end
    n_cmp++;
    if (rd_issued < 2) begin
      n_fail++;
      $display("FAIL empty_wait: got %0d reads, required 2", rd_issued);
    end
    @(posedge clk); #1;
    force_empty = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      n_cmp++;
      if (fifo_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_rd_%0d: got %0b, required 0", s, fifo_rd_en);
      end
      @(posedge clk); #1;
    end
    force_empty = 1'b0;
    wait_drain(40, ok);
    n_cmp++;
    if (!ok || hs_cnt != 4 || rd_issued != 4) begin
      n_fail++;
      $display("FAIL empty_result: got hs %0d reads %0d pending %0d, required 4 4 0", hs_cnt, rd_issued, exp_q.size());
    end
  endtask

  task automatic test_reset_midline();
    bit ok;
    int c;
    do_reset();
    m_ready = 1'b1;
    push_line();
    c = 0;
    while (rd_issued < 2 && c < 40) begin
      @(negedge clk); #1;
      c++;
    end
    n_cmp++;
    if (rd_issued < 2) begin
      n_fail++;
      $display("FAIL rstmid_wait: got %0d reads, required 2", rd_issued);
    end
    @(posedge clk); #1;
    rst = 1'b1; flush_req = 1'b1;
    clear_counters();
    @(negedge clk);
    n_cmp++;
    if ({fifo_rd_en, m_valid, m_sol, m_eol, m_sof, m_eof, line_done, m_data} !== 31'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h, required 0",
               {fifo_rd_en, m_valid, m_sol, m_eol, m_sof, m_eof, line_done, m_data});
    end
    @(posedge clk); #1;
    rst = 1'b0; flush_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_dropped: got valid=%0b data=%h, required valid=0", m_valid, m_data);
      end
    end
    @(posedge clk); #1;
    push_line();
    wait_drain(40, ok);
    n_cmp++;
    if (!ok || hs_cnt != 4 || sof_pos != 0) begin
      n_fail++;
      $display("FAIL rstmid_next: got hs %0d sof@%0d pending %0d, required 4 0 0", hs_cnt, sof_pos, exp_q.size());
    end
  endtask

  task automatic test_random();
    int lines_pushed;
    int cyc;
    do_reset();
    lines_pushed = 0;
    cyc = 0;
    while (hs_cnt < 100 * H && cyc < 20000) begin
      @(posedge clk); #1;
      m_ready     = ($urandom_range(0, 1) == 1);
      force_empty = ($urandom_range(0, 4) == 0);
      if (lines_pushed < 100 && (wr_idx - rd_idx) < 2 * H) begin
        push_line();
        lines_pushed++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    m_ready = 1'b0; force_empty = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (hs_cnt != 100 * H || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: got hs %0d pending %0d, required %0d 0", hs_cnt, exp_q.size(), 100 * H);
    end
    n_cmp++;
    if (ld_cnt != 100) begin
      n_fail++;
      $display("FAIL rand_line_done: got %0d, required 100", ld_cnt);
    end
    n_cmp++;
    if (sof_cnt != 50 || eof_cnt != 50) begin
      n_fail++;
      $display("FAIL rand_frames: got sof %0d eof %0d, required 50 50", sof_cnt, eof_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_two_lines();
    test_backpressure();
    test_empty_pause();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule
